// File: rtl/array_row_sequencer_if.sv
// Ready/valid operand and product bus for the sequential array-row multiplier.
interface array_row_sequencer_if #(
  parameter int unsigned WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;

  // Producer/consumer side: offers operands, accepts products.
  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  // Multiplier side: accepts operands, offers products.
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/array_row_sequencer.sv
// Sequential 8x8 unsigned multiplier: one array row reused for all eight
// partial-product rows, with partial sums fed back through registers.
module array_row_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  array_row_sequencer_if.slave  bus,
  output logic                  busy,
  output logic [2:0]            row_idx
);

  localparam int unsigned CW = 3;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH - 1;

  // The row datapath and row counter are sized for exactly eight rows.
  if (WIDTH != 8) begin : g_width_check
    $error("array_row_sequencer: WIDTH must be 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [WIDTH-1:0]  a_q,         a_d;
  logic [WIDTH-1:0]  b_q,         b_d;
  logic [WIDTH-1:0]  lo_q,        lo_d;
  logic [SW-1:0]     psum_q,      psum_d;
  logic              fc_q,        fc_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q,      busy_d;
  logic [CW-1:0]     row_idx_q,   row_idx_d;
  logic [PW-1:0]     product_q,   product_d;

  logic [WIDTH-1:0]  row_pp_c;
  logic [WIDTH:0]    row_total_c;
  logic              row_prod_c;
  logic [SW-1:0]     row_sum_c;
  logic              row_cout_c;

  // Array row: gated multiplicand plus the fed-back partial sum and top carry.
  always_comb begin
    row_pp_c    = a_q & {WIDTH{b_q[cnt_q]}};
    row_total_c = (WIDTH+1)'(row_pp_c) + (WIDTH+1)'({fc_q, psum_q});
    row_prod_c  = row_total_c[0];
    row_sum_c   = row_total_c[WIDTH-1:1];
    row_cout_c  = row_total_c[WIDTH];
  end

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    lo_d        = lo_q;
    psum_d      = psum_q;
    fc_d        = fc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          lo_d    = '0;
          psum_d  = '0;
          fc_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        lo_d[cnt_q] = row_prod_c;
        psum_d      = row_sum_c;
        fc_d        = row_cout_c;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) begin
          // Last row: assemble the product from the values being registered.
          product_d = {row_cout_c, row_sum_c, lo_d};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    row_idx_d   = (state_d == S_RUN) ? cnt_d : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      lo_q        <= '0;
      psum_q      <= '0;
      fc_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      row_idx_q   <= '0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lo_q        <= lo_d;
      psum_q      <= psum_d;
      fc_q        <= fc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      row_idx_q   <= row_idx_d;
      product_q   <= product_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign busy          = busy_q;
  assign row_idx       = row_idx_q;

endmodule
